// File: rtl/cpu_multicycle.sv
// Multicycle CPU: FETCH -> EXEC -> WB, 3 cycles per instruction when rom_ack is already high.
// Fetch stalls in FETCH with the PC held until rom_ack; HALT parks the core until reset.
module cpu_multicycle #(
  parameter int DW        = 8,
  parameter int PC_W      = 8,
  parameter int RAM_DEPTH = 256
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] rom_address,
  output logic            rom_req,
  input  logic            rom_ack,
  input  logic [7:0]      opcode1,
  input  logic [7:0]      opcode2,
  output logic            halted,
  output logic            Carry_f,
  output logic            Zero_f,
  output logic [15:0]     retired
);
  localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  typedef enum logic [1:0] {FETCH, EXEC, WB, HALT} state_t;
  state_t state, state_nxt;

  logic [PC_W-1:0] pc;
  logic [7:0]      ir1, ir2;
  logic [DW-1:0]   rf  [16];
  logic [DW-1:0]   ram [RAM_DEPTH];

  logic [DW-1:0] op_a, op_b, alu_res;
  logic          alu_c, ram_hit, jmp_cond;
  logic [AW-1:0] ram_idx;

  // Results evaluated in EXEC and held for the single WB commit
  logic [DW-1:0] ex_dat, wb_dat;
  logic [3:0]    ex_dst, wb_dst;
  logic          ex_reg_we, wb_reg_we, ex_ram_we, wb_ram_we, ex_flag_we, wb_flag_we;
  logic          ex_c, wb_c, ex_z, wb_z, ex_jmp, wb_jmp, ex_halt, wb_halt;

  assign ram_hit = ({24'd0, ir2} < 32'(RAM_DEPTH));
  assign ram_idx = ir2[AW-1:0];

  always_comb begin
    op_a    = rf[ir1[3:0]];
    op_b    = rf[ir2[7:4]];
    alu_res = '0;
    alu_c   = 1'b0;
    case (ir1[6:4])
      3'd0: {alu_c, alu_res} = {1'b0, op_a} + {1'b0, op_b};
      3'd1: begin alu_res = op_a - op_b; alu_c = (op_a < op_b); end
      3'd2: alu_res = op_a & op_b;
      3'd3: alu_res = op_a | op_b;
      3'd4: alu_res = op_a ^ op_b;
      3'd5: alu_res = ~op_a;
      3'd6: begin alu_res = {op_a[DW-2:0], op_a[DW-1]}; alu_c = op_a[DW-1]; end
      3'd7: begin alu_res = {op_a[0], op_a[DW-1:1]};    alu_c = op_a[0];    end
      default: ;
    endcase
  end

  always_comb begin
    case (ir1[2:0])
      3'b000:  jmp_cond = 1'b1;
      3'b001:  jmp_cond = Carry_f;
      3'b101:  jmp_cond = !Carry_f;
      3'b010:  jmp_cond = Zero_f;
      3'b110:  jmp_cond = !Zero_f;
      default: jmp_cond = 1'b0;
    endcase
  end

  always_comb begin
    ex_dat     = '0;
    ex_dst     = ir1[3:0];
    ex_reg_we  = 1'b0;
    ex_ram_we  = 1'b0;
    ex_flag_we = 1'b0;
    ex_c       = alu_c;
    ex_z       = (alu_res == '0);
    ex_jmp     = 1'b0;
    ex_halt    = 1'b0;
    if (ir1[7]) begin
      ex_dat     = alu_res;
      ex_dst     = ir2[3:0];
      ex_reg_we  = 1'b1;
      ex_flag_we = 1'b1;
    end else begin
      case (ir1[6:4])
        3'b001: begin ex_dat = DW'(ir2); ex_reg_we = 1'b1; end
        3'b010: begin ex_dat = ram_hit ? ram[ram_idx] : '0; ex_reg_we = 1'b1; end
        3'b011: begin ex_dat = op_a; ex_ram_we = ram_hit; end
        3'b100: ex_jmp = jmp_cond;
        3'b000: ex_halt = (ir1[3:0] == 4'hF);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    rom_req     = 1'b0;
    halted      = 1'b0;
    rom_address = pc;
    case (state)
      FETCH: begin
        rom_req = reset;
        if (rom_ack) state_nxt = EXEC;
      end
      EXEC:    state_nxt = WB;
      WB:      state_nxt = wb_halt ? HALT : FETCH;
      HALT:    halted = 1'b1;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= FETCH;
      pc      <= '0;
      ir1     <= '0;
      ir2     <= '0;
      Carry_f <= 1'b0;
      Zero_f  <= 1'b0;
      retired <= '0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && rom_ack) begin
        ir1 <= opcode1;
        ir2 <= opcode2;
      end
      if (state == WB) begin
        if (wb_reg_we) rf[wb_dst] <= wb_dat;
        if (wb_flag_we) begin
          Carry_f <= wb_c;
          Zero_f  <= wb_z;
        end
        if (!wb_halt) pc <= wb_jmp ? PC_W'(ir2) : pc + PC_W'(2);
        if (retired != 16'hFFFF) retired <= retired + 16'd1;
      end
    end
  end

  // Only loaded in EXEC and only consumed in WB, so no reset is needed
  always_ff @(posedge clk) begin
    if (state == EXEC) begin
      wb_dat     <= ex_dat;
      wb_dst     <= ex_dst;
      wb_reg_we  <= ex_reg_we;
      wb_ram_we  <= ex_ram_we;
      wb_flag_we <= ex_flag_we;
      wb_c       <= ex_c;
      wb_z       <= ex_z;
      wb_jmp     <= ex_jmp;
      wb_halt    <= ex_halt;
    end
  end

  // RAM keeps its contents through reset; a reset in WB still blocks the store
  always_ff @(posedge clk) begin
    if (reset && state == WB && wb_ram_we) ram[ram_idx] <= wb_dat;
  end
endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed plus randomized bench for cpu_multicycle (DW=8, PC_W=8, RAM_DEPTH=16)
// against an instruction-level reference model.
module tb_cpu_multicycle;
  logic       clk;
  logic       reset;
  logic [7:0] rom_address;
  logic       rom_req;
  logic       rom_ack;
  logic [7:0] opcode1;
  logic [7:0] opcode2;
  logic       halted;
  logic       Carry_f;
  logic       Zero_f;
  logic [15:0] retired;

  cpu_multicycle #(.DW(8), .PC_W(8), .RAM_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .rom_address(rom_address), .rom_req(rom_req),
    .rom_ack(rom_ack), .opcode1(opcode1), .opcode2(opcode2), .halted(halted),
    .Carry_f(Carry_f), .Zero_f(Zero_f), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int   m_rf [16];
  int   m_ram[16];
  int   m_pc, m_ret;
  logic m_c, m_z, m_halt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = 0;
    m_pc = 0; m_ret = 0; m_c = 1'b0; m_z = 1'b0; m_halt = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] o1, input logic [7:0] o2);
    int a, b, r;
    logic take;
    a = m_rf[o1[3:0]];
    b = m_rf[o2[7:4]];
    r = 0;
    take = 1'b0;
    if (o1[7]) begin
      m_c = 1'b0;
      case (o1[6:4])
        3'd0: begin r = a + b; m_c = (r > 255); end
        3'd1: begin r = a - b; m_c = (a < b); end
        3'd2: r = a & b;
        3'd3: r = a | b;
        3'd4: r = a ^ b;
        3'd5: r = 255 - a;
        3'd6: begin r = a * 2 + a / 128; m_c = (a >= 128); end
        default: begin r = a / 2 + (a % 2) * 128; m_c = (a % 2 == 1); end
      endcase
      r = r & 255;
      m_z = (r == 0);
      m_rf[o2[3:0]] = r;
    end else begin
      case (o1[7:4])
        4'h1: m_rf[o1[3:0]] = int'(o2);
        4'h2: m_rf[o1[3:0]] = (o2 < 16) ? m_ram[o2[3:0]] : 0;
        4'h3: if (o2 < 16) m_ram[o2[3:0]] = a;
        4'h4: case (o1[2:0])
                3'b000: take = 1'b1;
                3'b001: take = m_c;
                3'b101: take = !m_c;
                3'b010: take = m_z;
                3'b110: take = !m_z;
                default: take = 1'b0;
              endcase
        default: ;
      endcase
    end
    if (o1 == 8'h0F) m_halt = 1'b1;
    else m_pc = take ? int'(o2) : (m_pc + 2) % 256;
    if (m_ret < 65535) m_ret++;
  endtask

  task automatic check_arch(input string tag);
    chk({tag, ".pc"}, rom_address, m_pc);
    chk({tag, ".carry"}, Carry_f, m_c);
    chk({tag, ".zero"}, Zero_f, m_z);
    chk({tag, ".retired"}, retired, m_ret);
    chk({tag, ".halted"}, halted, m_halt);
    chk({tag, ".rom_req"}, rom_req, !m_halt);
    for (int i = 0; i < 16; i++) chk({tag, ".rf"}, dut.rf[i], m_rf[i]);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rom_ack = 1'b0;
    tick();
    chk("rst.rom_req0", rom_req, 0);
    tick();
    chk("rst.rom_req1", rom_req, 0);
    reset = 1'b1;
    #1;
    model_reset();
    check_arch("reset");
  endtask

  task automatic run_instr(input logic [7:0] o1, input logic [7:0] o2, input int stall);
    for (int i = 0; i < stall; i++) begin
      rom_ack = 1'b0;
      opcode1 = 8'($urandom);
      opcode2 = 8'($urandom);
      chk("stall.rom_req", rom_req, 1);
      chk("stall.pc", rom_address, m_pc);
      chk("stall.retired", retired, m_ret);
      tick();
    end
    chk("fetch.rom_req", rom_req, 1);
    chk("fetch.pc", rom_address, m_pc);
    rom_ack = 1'b1;
    opcode1 = o1;
    opcode2 = o2;
    tick();
    rom_ack = 1'($urandom);
    opcode1 = 8'($urandom);
    opcode2 = 8'($urandom);
    tick();
    tick();
    rom_ack = 1'b0;
    model_step(o1, o2);
    check_arch("instr");
  endtask

  task automatic abort_instr(input logic [7:0] o1, input logic [7:0] o2, input bit in_wb);
    rom_ack = 1'b1;
    opcode1 = o1;
    opcode2 = o2;
    tick();
    rom_ack = 1'b0;
    if (in_wb) tick();
    reset = 1'b0;
    #1;
    chk("abort.rom_req", rom_req, 0);
    tick();
    reset = 1'b1;
    #1;
    model_reset();
    check_arch("abort");
  endtask

  initial begin
    logic [7:0] o1, o2;
    reset = 1'b0;
    rom_ack = 1'b0;
    opcode1 = 8'h00;
    opcode2 = 8'h00;
    do_reset();

    // Give every RAM word a known value, then show reset leaves it alone
    for (int i = 0; i < 16; i++) begin
      run_instr(8'h19, 8'($urandom), 0);
      run_instr(8'h39, 8'(i), 0);
    end
    do_reset();

    run_instr(8'h11, 8'hF0, 0);
    run_instr(8'h12, 8'h20, 0);
    run_instr(8'h81, 8'h23, 0);
    chk("add.r3", dut.rf[3], 8'h10);
    chk("add.carry", Carry_f, 1);
    chk("add.zero", Zero_f, 0);
    chk("add.retired", retired, 3);

    run_instr(8'h33, 8'h05, 0);
    run_instr(8'h24, 8'h05, 0);
    chk("ld.r4", dut.rf[4], 8'h10);
    run_instr(8'h17, 8'h55, 0);
    run_instr(8'h37, 8'h20, 0);
    run_instr(8'h27, 8'h20, 0);
    chk("ld_oor.r7", dut.rf[7], 0);

    run_instr(8'h15, 8'h07, 0);
    run_instr(8'h95, 8'h55, 0);
    chk("sub.zero", Zero_f, 1);
    chk("sub.carry", Carry_f, 0);
    run_instr(8'h42, 8'h40, 0);
    chk("jz.pc", rom_address, 8'h40);
    run_instr(8'h46, 8'h80, 0);
    chk("jnz.pc", rom_address, 8'h42);

    run_instr(8'h18, 8'h3C, 4);
    chk("stall.r8", dut.rf[8], 8'h3C);

    for (int n = 0; n < 120; n++) begin
      o1 = 8'($urandom);
      if (o1 == 8'h0F) o1 = 8'h00;
      o2 = 8'($urandom);
      if (o1[7:4] == 4'h2 || o1[7:4] == 4'h3) o2 = 8'($urandom_range(0, 31));
      run_instr(o1, o2, $urandom_range(0, 2));
    end

    run_instr(8'h40, 8'hFE, 0);
    chk("wrap.pre", rom_address, 8'hFE);
    run_instr(8'h00, 8'h00, 0);
    chk("wrap.pc", rom_address, 8'h00);
    run_instr(8'h0F, 8'($urandom), 0);
    chk("halt.halted", halted, 1);
    for (int i = 0; i < 10; i++) begin
      rom_ack = 1'b1;
      opcode1 = 8'($urandom);
      opcode2 = 8'($urandom);
      tick();
      chk("halt.hold_pc", rom_address, m_pc);
      chk("halt.hold_req", rom_req, 0);
      chk("halt.hold_halted", halted, 1);
      chk("halt.hold_retired", retired, m_ret);
    end

    do_reset();
    abort_instr(8'h16, 8'hAA, 1'b1);
    chk("abort.r6", dut.rf[6], 0);
    chk("abort.retired", retired, 0);
    run_instr(8'h16, 8'h99, 0);
    abort_instr(8'h36, 8'h05, 1'b1);
    run_instr(8'h2A, 8'h05, 0);
    run_instr(8'h1B, 8'h66, 0);
    abort_instr(8'h3B, 8'h06, 1'b0);
    run_instr(8'h2C, 8'h06, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
